// File: rtl/rv_fetch_pkg.sv
// Shared types for the fetch-to-decode queue.
// One entry pairs an instruction word with its PC and PC+4.
package rv_fetch_pkg;

    localparam logic [31:0] NOP_ZERO = 32'h0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:2] pc;
        logic [31:2] pc_p4;
    } fetch_entry_t;

endpackage

// File: rtl/rv_fetch_queue_if.sv
// Fetch request/response and decode handshake bundle.
// The slave side is the queue, the master side is fetch plus decode.
interface rv_fetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          i_req;
    logic [29:0]   i_pc;
    logic [29:0]   i_pc_p4;
    logic          o_req_ready;
    logic [31:0]   i_data;
    logic          o_valid;
    logic          i_ready;
    logic [31:0]   o_instr;
    logic [29:0]   o_pc;
    logic [29:0]   o_pc_p4;
    logic [CW-1:0] o_count;

    modport master (
        output i_req, i_pc, i_pc_p4, i_data, i_ready,
        input  o_req_ready, o_valid, o_instr,
        input  o_pc, o_pc_p4, o_count
    );

    modport slave (
        input  i_req, i_pc, i_pc_p4, i_data, i_ready,
        output o_req_ready, o_valid, o_instr,
        output o_pc, o_pc_p4, o_count
    );

endinterface

// File: rtl/rv_fetch_fifo.sv
// Circular buffer of fetch entries with push, pop, flush and count.
// Pointers wrap naturally because DEPTH is a power of two.
module rv_fetch_fifo
    import rv_fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  fetch_entry_t  wdata,
    input  logic          pop,
    output fetch_entry_t  rdata,
    output logic          empty,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_q] = wdata;
                wr_d        = wr_q + 1'b1;
            end
            if (pop) begin
                rd_d = rd_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign rdata = mem_q[rd_q];
    assign empty = (cnt_q == '0);
    assign count = cnt_q;

endmodule

// File: rtl/rv_fetch_queue.sv
// Fetch-to-decode queue: in-flight slot, credit throttle,
// optional empty-queue bypass and flush shadow around rv_fetch_fifo.
module rv_fetch_queue
    import rv_fetch_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int BYPASS = 0,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_flush,
    rv_fetch_queue_if.slave  bus
);

    logic          inflight_q, inflight_d;
    logic          flush_q, flush_d;
    logic [29:0]   inf_pc_q, inf_pc_d;
    logic [29:0]   inf_pc_p4_q, inf_pc_p4_d;

    logic          credit;
    logic          req_ready;
    logic          req_acc;
    logic          resp_ok;
    logic          byp;
    logic          push;
    logic          pop;
    logic          head_ok;
    logic          empty;
    logic [CW-1:0] count;
    fetch_entry_t  wdata;
    fetch_entry_t  rdata;

    logic          valid;
    logic [31:0]   instr;
    logic [29:0]   pc;
    logic [29:0]   pc_p4;

    // The response slot is reserved at request time, so push never overflows.
    always_comb begin
        credit    = ({1'b0, count} + {{CW{1'b0}}, inflight_q})
                    < (CW+1)'(DEPTH);
        req_ready = !i_flush && credit;
        req_acc   = bus.i_req && req_ready;
        resp_ok   = inflight_q && !i_flush && !flush_q;
        byp       = (BYPASS != 0) && resp_ok && empty && bus.i_ready;
        push      = resp_ok && !byp;
        head_ok   = !empty && !i_flush && !flush_q;
        pop       = head_ok && bus.i_ready;
        wdata     = '{instr: bus.i_data, pc: inf_pc_q,
                      pc_p4: inf_pc_p4_q};
    end

    always_comb begin
        flush_d     = i_flush;
        inflight_d  = req_acc;
        inf_pc_d    = inf_pc_q;
        inf_pc_p4_d = inf_pc_p4_q;
        if (req_acc) begin
            inf_pc_d    = bus.i_pc;
            inf_pc_p4_d = bus.i_pc_p4;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            inflight_q  <= 1'b0;
            flush_q     <= 1'b0;
            inf_pc_q    <= '0;
            inf_pc_p4_q <= '0;
        end else begin
            inflight_q  <= inflight_d;
            flush_q     <= flush_d;
            inf_pc_q    <= inf_pc_d;
            inf_pc_p4_q <= inf_pc_p4_d;
        end
    end

    rv_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst   (i_reset),
        .flush (i_flush),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .rdata (rdata),
        .empty (empty),
        .count (count)
    );

    always_comb begin
        valid = 1'b0;
        instr = NOP_ZERO;
        pc    = '0;
        pc_p4 = '0;
        if (byp) begin
            valid = 1'b1;
            instr = bus.i_data;
            pc    = inf_pc_q;
            pc_p4 = inf_pc_p4_q;
        end else if (head_ok) begin
            valid = 1'b1;
            instr = rdata.instr;
            pc    = rdata.pc;
            pc_p4 = rdata.pc_p4;
        end
    end

    assign bus.o_req_ready = req_ready;
    assign bus.o_valid     = valid;
    assign bus.o_instr     = instr;
    assign bus.o_pc        = pc;
    assign bus.o_pc_p4     = pc_p4;
    assign bus.o_count     = count;

endmodule

// File: tb/tb_rv_fetch_queue.sv
// Directed bench for rv_fetch_queue, BYPASS=0 (f0) and BYPASS=1 (f1)
// instances share the same stimulus.
module tb_rv_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        req;
    logic        rdy;
    logic [29:0] pc;
    logic [29:0] pcp4;
    logic [31:0] data;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    rv_fetch_queue_if #(.DEPTH(4)) f0 ();
    rv_fetch_queue_if #(.DEPTH(4)) f1 ();

    assign f0.i_req   = req;
    assign f0.i_pc    = pc;
    assign f0.i_pc_p4 = pcp4;
    assign f0.i_data  = data;
    assign f0.i_ready = rdy;
    assign f1.i_req   = req;
    assign f1.i_pc    = pc;
    assign f1.i_pc_p4 = pcp4;
    assign f1.i_data  = data;
    assign f1.i_ready = rdy;

    rv_fetch_queue #(.DEPTH(4), .BYPASS(0)) dut0 (
        .i_clk   (clk),
        .i_reset (rst),
        .i_flush (flush),
        .bus     (f0.slave)
    );

    rv_fetch_queue #(.DEPTH(4), .BYPASS(1)) dut1 (
        .i_clk   (clk),
        .i_reset (rst),
        .i_flush (flush),
        .bus     (f1.slave)
    );

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req   = 1'b0;
        flush = 1'b0;
        pc    = '0;
        pcp4  = '0;
        data  = '0;
    endtask

    int          m_inf;
    logic [31:0] m_w;
    logic [29:0] m_pc;
    logic [31:0] mq [$];
    logic [29:0] mpc [$];
    int          sent;
    int          got;
    logic        exp_rr;

    initial begin
        rst = 1'b1;
        rdy = 1'b0;
        idle();
        #2;
        chk("rst_v0", f0.o_valid, 0);
        chk("rst_i0", f0.o_instr, 0);
        chk("rst_c0", f0.o_count, 0);
        chk("rst_rr0", f0.o_req_ready, 1);
        chk("rst_v1", f1.o_valid, 0);
        chk("rst_rr1", f1.o_req_ready, 1);
        tick();
        rst = 1'b0;

        // latency: cycle N request
        tick();
        req = 1'b1; pc = 30'h40; pcp4 = 30'h41; rdy = 1'b1;
        #2;
        chk("lat_rr0", f0.o_req_ready, 1);
        chk("lat_rr1", f1.o_req_ready, 1);
        tick();
        idle(); data = 32'h0000_0013;
        #2;
        chk("lat1_v0", f0.o_valid, 0);
        chk("lat1_v1", f1.o_valid, 1);
        chk("lat1_i1", f1.o_instr, 32'h13);
        chk("lat1_p1", f1.o_pc, 30'h40);
        chk("lat1_q1", f1.o_pc_p4, 30'h41);
        tick();
        idle();
        #2;
        chk("lat2_v0", f0.o_valid, 1);
        chk("lat2_i0", f0.o_instr, 32'h13);
        chk("lat2_p0", f0.o_pc, 30'h40);
        chk("lat2_q0", f0.o_pc_p4, 30'h41);
        chk("lat2_c0", f0.o_count, 1);
        chk("lat2_v1", f1.o_valid, 0);
        chk("lat2_c1", f1.o_count, 0);
        tick();
        #2;
        chk("lat3_v0", f0.o_valid, 0);
        chk("lat3_c0", f0.o_count, 0);

        // fill with decode stalled
        rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            idle();
            req  = (k < 4);
            pc   = 30'h200 + 30'(k);
            pcp4 = 30'h201 + 30'(k);
            data = (k > 0) ? 32'h1000_0000 + 32'(k - 1) : 32'h0;
            #2;
            chk("fill_rr0", f0.o_req_ready, (k < 4));
            chk("fill_rr1", f1.o_req_ready, (k < 4));
        end
        // drain in order
        for (int j = 0; j < 4; j++) begin
            tick();
            idle(); rdy = 1'b1;
            #2;
            chk("drn_c0", f0.o_count, 4 - j);
            chk("drn_rr0", f0.o_req_ready, (j > 0));
            chk("drn_v0", f0.o_valid, 1);
            chk("drn_i0", f0.o_instr, 32'h1000_0000 + 32'(j));
            chk("drn_p0", f0.o_pc, 30'h200 + 30'(j));
            chk("drn_i1", f1.o_instr, 32'h1000_0000 + 32'(j));
        end
        tick();
        #2;
        chk("drn_end_v0", f0.o_valid, 0);
        chk("drn_end_c0", f0.o_count, 0);

        // streaming across pointer wrap, checked on f0
        m_inf = 0; m_w = '0; m_pc = '0; sent = 0; got = 0;
        for (int t = 0; t < 120 && got < 12; t++) begin
            tick();
            idle();
            rdy    = ((t % 3) != 2);
            exp_rr = (mq.size() + m_inf) < 4;
            req    = exp_rr && (sent < 12);
            pc     = 30'h400 + 30'(sent);
            pcp4   = 30'h401 + 30'(sent);
            data   = (m_inf != 0) ? m_w : 32'h0;
            #2;
            chk("s_rr", f0.o_req_ready, exp_rr);
            chk("s_cnt", f0.o_count, mq.size());
            if (mq.size() > 0) begin
                chk("s_v", f0.o_valid, 1);
                chk("s_i", f0.o_instr, mq[0]);
                chk("s_p", f0.o_pc, mpc[0]);
            end else begin
                chk("s_v", f0.o_valid, 0);
            end
            if (mq.size() > 0 && rdy) begin
                void'(mq.pop_front());
                void'(mpc.pop_front());
                got++;
            end
            if (m_inf != 0) begin
                mq.push_back(m_w);
                mpc.push_back(m_pc);
            end
            m_inf = req ? 1 : 0;
            if (req) begin
                m_w  = 32'hC0DE_0000 + 32'(sent);
                m_pc = pc;
                sent++;
            end
        end
        chk("s_got", got, 12);
        for (int t = 0; t < 4; t++) begin
            tick();
            idle(); rdy = 1'b1;
        end
        #2;
        chk("s_end_c0", f0.o_count, 0);
        chk("s_end_c1", f1.o_count, 0);

        // flush with 3 queued and one in flight
        rdy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            idle();
            req  = 1'b1;
            pc   = 30'h300 + 30'(k);
            pcp4 = 30'h301 + 30'(k);
            data = (k > 0) ? 32'hF000_0000 + 32'(k - 1) : 32'h0;
            #2;
            chk("fl_rr0", f0.o_req_ready, 1);
        end
        tick();
        idle(); flush = 1'b1; data = 32'hDEAD_BEEF; rdy = 1'b1;
        #2;
        chk("fl0_c0", f0.o_count, 3);
        chk("fl0_v0", f0.o_valid, 0);
        chk("fl0_i0", f0.o_instr, 0);
        chk("fl0_rr0", f0.o_req_ready, 0);
        chk("fl0_v1", f1.o_valid, 0);
        tick();
        idle(); data = 32'hDEAD_BEEF;
        #2;
        chk("fl1_v0", f0.o_valid, 0);
        chk("fl1_v1", f1.o_valid, 0);
        chk("fl1_i1", f1.o_instr, 0);
        chk("fl1_c0", f0.o_count, 0);
        chk("fl1_rr0", f0.o_req_ready, 1);
        tick();
        idle();
        #2;
        chk("fl2_v0", f0.o_valid, 0);
        chk("fl2_c0", f0.o_count, 0);
        chk("fl2_c1", f1.o_count, 0);

        // request in the flush cycle is ignored
        rdy = 1'b0;
        tick();
        idle(); req = 1'b1; pc = 30'h500; pcp4 = 30'h501;
        #2;
        tick();
        idle(); flush = 1'b1; req = 1'b1;
        pc = 30'h5FF; pcp4 = 30'h600; data = 32'hAAAA_0001;
        #2;
        chk("fr0_rr0", f0.o_req_ready, 0);
        chk("fr0_rr1", f1.o_req_ready, 0);
        tick();
        idle(); req = 1'b1; pc = 30'h600; pcp4 = 30'h601;
        data = 32'hBAD0_BAD0;
        #2;
        chk("fr1_rr0", f0.o_req_ready, 1);
        chk("fr1_v0", f0.o_valid, 0);
        chk("fr1_v1", f1.o_valid, 0);
        tick();
        idle(); data = 32'h600D_0001;
        #2;
        chk("fr2_c0", f0.o_count, 0);
        tick();
        idle(); rdy = 1'b1;
        #2;
        chk("fr3_v0", f0.o_valid, 1);
        chk("fr3_i0", f0.o_instr, 32'h600D_0001);
        chk("fr3_p0", f0.o_pc, 30'h600);
        chk("fr3_c0", f0.o_count, 1);
        chk("fr3_i1", f1.o_instr, 32'h600D_0001);
        tick();
        idle();
        #2;
        chk("fr4_v0", f0.o_valid, 0);
        chk("fr4_c0", f0.o_count, 0);

        // asynchronous reset while half full
        rdy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            idle();
            req  = (k < 3);
            pc   = 30'h700 + 30'(k);
            pcp4 = 30'h701 + 30'(k);
            data = (k > 0) ? 32'h7000_0000 + 32'(k - 1) : 32'h0;
        end
        #2;
        chk("ar_v0", f0.o_valid, 1);
        chk("ar_i0", f0.o_instr, 32'h7000_0000);
        chk("ar_c0", f0.o_count, 2);
        idle();
        rst = 1'b1;
        #1;
        chk("ar_rv0", f0.o_valid, 0);
        chk("ar_ri0", f0.o_instr, 0);
        chk("ar_rp0", f0.o_pc, 0);
        chk("ar_rq0", f0.o_pc_p4, 0);
        chk("ar_rc0", f0.o_count, 0);
        chk("ar_rr0", f0.o_req_ready, 1);
        chk("ar_rc1", f1.o_count, 0);
        tick();
        rst = 1'b0;
        data = 32'h7000_0002;
        rdy  = 1'b1;
        #2;
        chk("ar_post_v0", f0.o_valid, 0);
        chk("ar_post_v1", f1.o_valid, 0);
        tick();
        #2;
        chk("ar_post_c0", f0.o_count, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
